// File: rtl/syn_array_seq_pkg.sv
// Shared definitions for the synapse-array sequencer: config word layout,
// FSM encoding and the default multiply+accumulate latency.
package syn_array_seq_pkg;

  localparam int unsigned CFG_W          = 16;
  localparam int unsigned LAT_DEFAULT    = 2;

  // cfgdat field offsets as seen by each synapse cell
  localparam int unsigned CFG_EXE_EN_BIT = 15;
  localparam int unsigned CFG_SEL_HZ_LSB = 13;
  localparam int unsigned CFG_SEL_VT_LSB = 11;
  localparam int unsigned CFG_SEL_OP_LSB = 8;
  localparam int unsigned CFG_SEL_W      = 2;
  localparam int unsigned CFG_OP_W       = 3;

  typedef struct packed {
    logic                exe_en;
    logic [CFG_SEL_W-1:0] sel_hz;
    logic [CFG_SEL_W-1:0] sel_vt;
    logic [CFG_OP_W-1:0]  sel_op;
    logic [7:0]           rsvd;
  } cfg_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/syn_array_seq_if.sv
// Control/broadcast bundle between the sequencer and its host / synapse array.
interface syn_array_seq_if
  import syn_array_seq_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned CLMS      = 4,
  parameter int unsigned ADDR_DMEM = 8,
  parameter int unsigned ADDR_CMEM = 4
);

  logic                 start;
  logic                 stall;
  logic [ADDR_CMEM-1:0] prog_len;
  logic [ADDR_DMEM-1:0] vec_len;
  logic                 cfg_we;
  logic [ADDR_CMEM-1:0] cfg_waddr;
  logic [CFG_W-1:0]     cfg_wdata;

  logic                 busy;
  logic                 done;
  logic [CFG_W-1:0]     cfgdat;
  logic [ROWS-1:0]      row_en;
  logic [CLMS-1:0]      clm_en;
  logic [ROWS-1:0]      row_rd;
  logic [CLMS-1:0]      clm_rd;
  logic                 rtm_en;
  logic [ADDR_DMEM-1:0] r_addr;
  logic [ADDR_DMEM-1:0] w_addr;

  modport master (
    output start, stall, prog_len, vec_len, cfg_we, cfg_waddr, cfg_wdata,
    input  busy, done, cfgdat, row_en, clm_en, row_rd, clm_rd, rtm_en, r_addr, w_addr
  );

  modport slave (
    input  start, stall, prog_len, vec_len, cfg_we, cfg_waddr, cfg_wdata,
    output busy, done, cfgdat, row_en, clm_en, row_rd, clm_rd, rtm_en, r_addr, w_addr
  );

endinterface

// File: rtl/syn_cfg_mem.sv
// Simple dual-port program RAM: one write port, one registered read port.
module syn_cfg_mem
  import syn_array_seq_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = CFG_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Contents survive reset; only the sequencer state is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/syn_array_seq.sv
// Synapse-array sequencer: steps through the config program and emits a
// skewed row/column enable wavefront plus data-memory addressing per step.
module syn_array_seq
  import syn_array_seq_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned CLMS      = 4,
  parameter int unsigned ADDR_DMEM = 8,
  parameter int unsigned ADDR_CMEM = 4,
  parameter int unsigned LAT       = LAT_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  syn_array_seq_if.slave  bus
);

  localparam int unsigned MAXRC = (ROWS > CLMS) ? ROWS : CLMS;
  // Beat counter must reach vec_len + MAXRC - 1 + LAT without wrapping.
  localparam int unsigned TW    = ADDR_DMEM + $clog2(MAXRC + LAT) + 1;

  seq_state_e           state_q, state_d;
  logic [ADDR_CMEM-1:0] step_q, step_d, step_nx;
  logic [ADDR_CMEM-1:0] plen_q, plen_d;
  logic [ADDR_DMEM-1:0] vlen_q, vlen_d;
  logic [TW-1:0]        t_q, t_d;
  logic [TW-1:0]        vl_ext, t_end;
  logic                 step_end;
  logic                 mem_we, mem_re;
  logic [CFG_W-1:0]     mem_rdata;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CFG_W-1:0]     cfgdat_q, cfgdat_d;
  logic [ROWS-1:0]      row_en_q, row_en_d;
  logic [CLMS-1:0]      clm_en_q, clm_en_d;
  logic [ROWS-1:0]      row_rd_q, row_rd_d;
  logic [CLMS-1:0]      clm_rd_q, clm_rd_d;
  logic                 rtm_en_q, rtm_en_d;
  logic [ADDR_DMEM-1:0] r_addr_q, r_addr_d;
  logic [ADDR_DMEM-1:0] w_addr_q, w_addr_d;

  assign mem_we  = bus.cfg_we && (state_q == ST_IDLE);
  assign vl_ext  = TW'(vlen_q);
  assign t_end   = vl_ext + TW'(MAXRC - 1 + LAT);
  assign step_nx = step_q + ADDR_CMEM'(1);

  syn_cfg_mem #(
    .AW (ADDR_CMEM),
    .DW (CFG_W)
  ) u_cfg_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.cfg_waddr),
    .wdata (bus.cfg_wdata),
    .re    (mem_re),
    .raddr (step_q),
    .rdata (mem_rdata)
  );

  // Next-state and next-output logic; all outputs leave through registers.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    plen_d   = plen_q;
    vlen_d   = vlen_q;
    t_d      = t_q;
    step_end = 1'b0;
    mem_re   = 1'b0;
    cfgdat_d = cfgdat_q;
    row_en_d = '0;
    clm_en_d = '0;
    row_rd_d = '0;
    clm_rd_d = '0;
    rtm_en_d = 1'b0;
    r_addr_d = r_addr_q;
    w_addr_d = w_addr_q;
    busy_d   = (state_q == ST_LOAD) || (state_q == ST_RUN);
    done_d   = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          plen_d  = bus.prog_len;
          vlen_d  = bus.vec_len;
          step_d  = '0;
          t_d     = '0;
          state_d = (bus.prog_len == '0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        mem_re  = 1'b1;
        t_d     = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // Read data lands in the first RUN cycle; hold it for the whole step.
        if (t_q == '0) cfgdat_d = mem_rdata;

        if (vlen_q == '0) begin
          step_end = 1'b1;
        end else if (!bus.stall) begin
          for (int i = 0; i < int'(ROWS); i++) begin
            row_en_d[i] = (t_q >= TW'(i)) && (t_q < vl_ext + TW'(i));
            row_rd_d[i] = (t_q >= TW'(i) + TW'(LAT)) && (t_q < vl_ext + TW'(i) + TW'(LAT));
          end
          for (int j = 0; j < int'(CLMS); j++) begin
            clm_en_d[j] = (t_q >= TW'(j)) && (t_q < vl_ext + TW'(j));
            clm_rd_d[j] = (t_q >= TW'(j) + TW'(LAT)) && (t_q < vl_ext + TW'(j) + TW'(LAT));
          end
          rtm_en_d = (t_q >= TW'(LAT)) && (t_q < vl_ext + TW'(LAT));
          r_addr_d = (t_q < vl_ext) ? ADDR_DMEM'(t_q) : (vlen_q - ADDR_DMEM'(1));
          if (rtm_en_d) w_addr_d = ADDR_DMEM'(t_q - TW'(LAT));

          if (t_q == t_end) step_end = 1'b1;
          else              t_d      = t_q + TW'(1);
        end

        if (step_end) begin
          step_d  = step_nx;
          state_d = (step_nx == plen_q) ? ST_DONE : ST_LOAD;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      plen_q   <= '0;
      vlen_q   <= '0;
      t_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cfgdat_q <= '0;
      row_en_q <= '0;
      clm_en_q <= '0;
      row_rd_q <= '0;
      clm_rd_q <= '0;
      rtm_en_q <= 1'b0;
      r_addr_q <= '0;
      w_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      plen_q   <= plen_d;
      vlen_q   <= vlen_d;
      t_q      <= t_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cfgdat_q <= cfgdat_d;
      row_en_q <= row_en_d;
      clm_en_q <= clm_en_d;
      row_rd_q <= row_rd_d;
      clm_rd_q <= clm_rd_d;
      rtm_en_q <= rtm_en_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.cfgdat = cfgdat_q;
  assign bus.row_en = row_en_q;
  assign bus.clm_en = clm_en_q;
  assign bus.row_rd = row_rd_q;
  assign bus.clm_rd = clm_rd_q;
  assign bus.rtm_en = rtm_en_q;
  assign bus.r_addr = r_addr_q;
  assign bus.w_addr = w_addr_q;

endmodule

// File: tb/tb_syn_array_seq.sv
// Scoreboard bench for syn_array_seq: stimulus queues expected beats and
// done summaries, a negedge monitor pops and compares them.
module tb_syn_array_seq;
  import syn_array_seq_pkg::*;

  localparam int unsigned ROWS      = 4;
  localparam int unsigned CLMS      = 4;
  localparam int unsigned ADDR_DMEM = 8;
  localparam int unsigned ADDR_CMEM = 4;
  localparam int unsigned LAT       = 2;
  localparam int          LATI      = 2;
  localparam int          T_TAIL    = 3 + LATI;  // max(ROWS,CLMS)-1+LAT

  typedef struct packed {
    logic [ROWS-1:0]      row_en;
    logic [CLMS-1:0]      clm_en;
    logic [ROWS-1:0]      row_rd;
    logic [CLMS-1:0]      clm_rd;
    logic                 rtm_en;
    logic [ADDR_DMEM-1:0] r_addr;
    logic [ADDR_DMEM-1:0] w_addr;
    logic [15:0]          cfg;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   done_seen = 0;
  int   rtm_cnt   = 0;
  beat_t       exp_q[$];
  int          exp_done[$];
  logic [15:0] shadow [16];
  beat_t       mb;

  syn_array_seq_if #(.ROWS(ROWS), .CLMS(CLMS), .ADDR_DMEM(ADDR_DMEM), .ADDR_CMEM(ADDR_CMEM)) bus ();

  syn_array_seq #(
    .ROWS(ROWS), .CLMS(CLMS), .ADDR_DMEM(ADDR_DMEM), .ADDR_CMEM(ADDR_CMEM), .LAT(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t model(input int t, input int vl, input logic [15:0] cfg);
    beat_t b;
    b = '0;
    b.cfg = cfg;
    for (int i = 0; i < int'(ROWS); i++) begin
      b.row_en[i] = (t >= i) && (t < vl + i);
      b.row_rd[i] = (t >= i + LATI) && (t < vl + i + LATI);
    end
    for (int j = 0; j < int'(CLMS); j++) begin
      b.clm_en[j] = (t >= j) && (t < vl + j);
      b.clm_rd[j] = (t >= j + LATI) && (t < vl + j + LATI);
    end
    b.rtm_en = (t >= LATI) && (t < vl + LATI);
    b.r_addr = (t < vl) ? ADDR_DMEM'(t) : ADDR_DMEM'(vl - 1);
    b.w_addr = ADDR_DMEM'(t - LATI);
    return b;
  endfunction

  task automatic push_prog(input int plen, input int vl);
    for (int s = 0; s < plen; s++) begin
      for (int t = 0; t < vl + T_TAIL && vl > 0; t++) begin
        beat_t b;
        b = model(t, vl, shadow[s]);
        if ((b.row_en | b.clm_en | b.row_rd | b.clm_rd) != '0 || b.rtm_en)
          exp_q.push_back(b);
      end
    end
    exp_done.push_back(plen * vl);
  endtask

  task automatic cfg_write(input int addr, input logic [15:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_waddr = ADDR_CMEM'(addr);
    bus.cfg_wdata = data;
    @(posedge clk); #1;
    bus.cfg_we    = 1'b0;
    shadow[addr]  = data;
  endtask

  task automatic start_prog(input int plen, input int vl);
    bus.prog_len = ADDR_CMEM'(plen);
    bus.vec_len  = ADDR_DMEM'(vl);
    push_prog(plen, vl);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget);
    int n;
    n = 0;
    while (done_seen == c0 && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    if (done_seen == c0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: actual=no done expected=done within %0d cycles", budget);
    end
  endtask

  // Scoreboard monitor: every cycle with any enable asserted is one beat.
  always @(negedge clk) begin
    if (rst) begin
      rtm_cnt = 0;
    end else begin
      if ((bus.row_en | bus.clm_en | bus.row_rd | bus.clm_rd) != '0 || bus.rtm_en) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: actual row_en=%0h rtm_en=%0b expected=no beat at %0t",
                   bus.row_en, bus.rtm_en, $time);
        end else begin
          mb = exp_q.pop_front();
          chk("row_en", 32'(bus.row_en), 32'(mb.row_en));
          chk("clm_en", 32'(bus.clm_en), 32'(mb.clm_en));
          chk("row_rd", 32'(bus.row_rd), 32'(mb.row_rd));
          chk("clm_rd", 32'(bus.clm_rd), 32'(mb.clm_rd));
          chk("rtm_en", 32'(bus.rtm_en), 32'(mb.rtm_en));
          chk("r_addr", 32'(bus.r_addr), 32'(mb.r_addr));
          chk("cfgdat", 32'(bus.cfgdat), 32'(mb.cfg));
          if (mb.rtm_en) chk("w_addr", 32'(bus.w_addr), 32'(mb.w_addr));
        end
        if (bus.rtm_en) rtm_cnt++;
      end
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: actual=done pulse expected=none at %0t", $time);
        end else begin
          chk("rtm_beats_per_prog", 32'(rtm_cnt), 32'(exp_done.pop_front()));
        end
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        rtm_cnt = 0;
        done_seen++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic found;
    rst = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.prog_len = '0; bus.vec_len = '0;
    bus.cfg_we = 1'b0; bus.cfg_waddr = '0; bus.cfg_wdata = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 16'h0;
    bus.start = 1'b1;  // start together with reset: reset must win
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_cfgdat", 32'(bus.cfgdat), 32'd0);
    chk("rst_enables", 32'({bus.row_en, bus.clm_en, bus.row_rd, bus.clm_rd, bus.rtm_en}), 32'd0);
    chk("rst_r_addr", 32'(bus.r_addr), 32'd0);
    chk("rst_w_addr", 32'(bus.w_addr), 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    cfg_write(0, 16'h8000);
    cfg_write(1, 16'hC123);
    cfg_write(2, 16'h4A5A);

    // Two steps, three beats each
    c0 = done_seen;
    start_prog(2, 3);
    wait_done(c0, 200);
    repeat (5) @(posedge clk); #1;
    chk("single_done", 32'(done_seen - c0), 32'd1);
    chk("busy_after",  32'(bus.busy), 32'd0);
    chk("beats_drained_1", 32'(exp_q.size()), 32'd0);

    // Empty program: DONE straight from IDLE, done two cycles after start
    c0 = done_seen;
    start_prog(0, 3);
    @(negedge clk);
    chk("empty_done_early", 32'(bus.done), 32'd0);
    chk("empty_busy_1",     32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("empty_done_2cyc",  32'(bus.done), 32'd1);
    chk("empty_busy_2",     32'(bus.busy), 32'd0);
    wait_done(c0, 20);

    // Zero-length vectors: three LOAD/RUN pairs, no beats
    repeat (2) @(posedge clk); #1;
    c0 = done_seen;
    start_prog(3, 0);
    wait_done(c0, 100);
    chk("vl0_beats_drained", 32'(exp_q.size()), 32'd0);

    // Two stall cycles while beat 2 is on the outputs
    repeat (2) @(posedge clk); #1;
    c0 = done_seen;
    start_prog(1, 4);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (bus.row_en != '0 && bus.r_addr == 8'd2) found = 1'b1;
    end
    chk("stall_sync", 32'(found), 32'd1);
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_enables_zero",
          32'({bus.row_en, bus.clm_en, bus.row_rd, bus.clm_rd, bus.rtm_en}), 32'd0);
      chk("stall_r_addr", 32'(bus.r_addr), 32'd2);
      chk("stall_busy",   32'(bus.busy),   32'd1);
    end
    bus.stall = 1'b0;
    wait_done(c0, 200);
    chk("stall_beats_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of step 0
    repeat (2) @(posedge clk); #1;
    c0 = done_seen;
    start_prog(2, 3);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (bus.row_en[3]) found = 1'b1;
    end
    chk("abort_sync", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",   32'(bus.busy),   32'd0);
    chk("abort_done",   32'(bus.done),   32'd0);
    chk("abort_cfgdat", 32'(bus.cfgdat), 32'd0);
    chk("abort_enables", 32'({bus.row_en, bus.clm_en, bus.row_rd, bus.clm_rd, bus.rtm_en}), 32'd0);
    chk("abort_r_addr", 32'(bus.r_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_done.delete();
    repeat (8) @(posedge clk); #1;
    chk("abort_no_done", 32'(done_seen - c0), 32'd0);
    c0 = done_seen;
    start_prog(2, 3);
    wait_done(c0, 200);
    chk("post_abort_drained", 32'(exp_q.size()), 32'd0);

    // Program write while running must be ignored
    repeat (2) @(posedge clk); #1;
    c0 = done_seen;
    start_prog(2, 3);
    repeat (4) @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_waddr = 4'd1; bus.cfg_wdata = 16'hFFFF;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    wait_done(c0, 200);
    chk("we_ignored_drained", 32'(exp_q.size()), 32'd0);

    repeat (4) @(posedge clk); #1;
    chk("final_done_queue", 32'(exp_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
